// File: rtl/i2c_pkg.sv
// Shared definitions for the SCCB/I2C slave: FSM encoding, default OV7725
// device address, R/W bit position and the register-pointer increment.
package i2c_pkg;

   localparam logic [6:0]  OV7725_DEV_ADDR = 7'h21;
   localparam int unsigned RW_BIT          = 0;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_DEV_ADDR = 4'd1,
      ST_DEV_ACK  = 4'd2,
      ST_REG_ADDR = 4'd3,
      ST_REG_ACK  = 4'd4,
      ST_WR_DATA  = 4'd5,
      ST_WR_ACK   = 4'd6,
      ST_RD_LOAD  = 4'd7,
      ST_RD_DATA  = 4'd8,
      ST_RD_ACK   = 4'd9,
      ST_IGNORE   = 4'd10
   } i2c_state_e;

   // Register pointer advance with natural 8-bit wrap (0xFF -> 0x00).
   function automatic logic [7:0] addr_inc(input logic [7:0] a);
      return a + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and bus-event detector for the I2C slave.
// Produces single-cycle scl_rise / scl_fall / start_det / stop_det pulses
// from the synchronized (and optionally filtered) bus lines.
// Optional: define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter
// on both lines after synchronization (suppresses spikes under 3 clk).
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_raw;
   logic                   sda_raw;
   logic                   scl;
   logic                   scl_d;
   logic                   sda_d;

   // synchronizer chains, preset to the idle (released) bus level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

   assign scl_raw = scl_sync[SYNC_STAGES-1];
   assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;
   logic       scl_filt;
   logic       sda_filt;

   // filtered level only follows the line once three consecutive samples agree
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_hist <= '1;
         sda_hist <= '1;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_raw};
         sda_hist <= {sda_hist[0], sda_raw};
         if (scl_raw == scl_hist[0] && scl_raw == scl_hist[1])
            scl_filt <= scl_raw;
         if (sda_raw == sda_hist[0] && sda_raw == sda_hist[1])
            sda_filt <= sda_raw;
      end
   end

   assign scl = scl_filt;
   assign sda = sda_filt;
`else
   assign scl = scl_raw;
   assign sda = sda_raw;
`endif

   // previous-sample registers for edge and START/STOP detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl;
         sda_d <= sda;
      end
   end

   assign scl_rise  =  scl & ~scl_d;
   assign scl_fall  = ~scl &  scl_d;
   assign start_det =  scl &  scl_d &  sda_d & ~sda;
   assign stop_det  =  scl &  scl_d & ~sda_d &  sda;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// SCCB/I2C slave emulating an OV7725-style register target.
// Bus is oversampled by clk; register accesses appear as one-cycle
// reg_wr / reg_rd strobes on a simple 8-bit address/data interface.
// Optional: I2C_GLITCH_FILTER_EN (see i2c_bus_sync) adds spike filtering.
// HOLD_CYC must be at least 1.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = OV7725_DEV_ADDR,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYC    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       i2c_busy,
   output logic       addr_hit
);

   localparam int unsigned HW = $clog2(HOLD_CYC + 1);

   i2c_state_e    state;
   i2c_state_e    state_nxt;
   logic          sda;
   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    rx_byte;
   logic          last_bit;
   logic          addr_match;
   logic          rw_bit;
   logic          ld_cnt;
   logic [HW-1:0] hold_cnt;
   logic          sda_oe;
   logic          drive_low;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (i2c_sclk),
      .sda_in    (i2c_sdat),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // open-drain output; reset releases the line without waiting for a clock
   assign i2c_sdat = (sda_oe && !rst) ? 1'b0 : 1'bz;

   assign rx_byte    = {shreg[6:0], sda};
   assign last_bit   = (bit_cnt == 3'd7);
   assign addr_match = (rx_byte[7:1] == DEV_ADDR);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // next state, read request and the SDA level to apply after the hold delay.
   // All byte/ACK transitions happen on SCL rise; SDA only changes HOLD_CYC
   // after the following fall, using the state current at that time.
   always_comb begin
      state_nxt = state;
      reg_rd    = 1'b0;
      drive_low = 1'b0;
      if (stop_det) begin
         state_nxt = ST_IDLE;
      end else if (start_det) begin
         state_nxt = ST_DEV_ADDR;
      end else begin
         case (state)
            ST_DEV_ADDR: if (scl_rise && last_bit)
                            state_nxt = addr_match ? ST_DEV_ACK : ST_IGNORE;
            ST_DEV_ACK:  if (scl_rise)
                            state_nxt = rw_bit ? ST_RD_LOAD : ST_REG_ADDR;
            ST_REG_ADDR: if (scl_rise && last_bit) state_nxt = ST_REG_ACK;
            ST_REG_ACK:  if (scl_rise) state_nxt = ST_WR_DATA;
            ST_WR_DATA:  if (scl_rise && last_bit) state_nxt = ST_WR_ACK;
            ST_WR_ACK:   if (scl_rise) state_nxt = ST_WR_DATA;
            ST_RD_LOAD:  if (ld_cnt) state_nxt = ST_RD_DATA;
            ST_RD_DATA:  if (scl_rise && last_bit) state_nxt = ST_RD_ACK;
            ST_RD_ACK:   if (scl_rise) state_nxt = sda ? ST_IGNORE : ST_RD_LOAD;
            default:     ;
         endcase
      end
      if (state == ST_RD_LOAD && !ld_cnt)
         reg_rd = 1'b1;
      case (state)
         ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: drive_low = 1'b1;
         ST_RD_DATA:                        drive_low = ~shreg[7];
         default:                           drive_low = 1'b0;
      endcase
   end

   // datapath: shift register, bit count, register pointer, strobes, SDA timing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         rw_bit    <= 1'b0;
         ld_cnt    <= 1'b0;
         hold_cnt  <= '0;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         addr_hit  <= 1'b0;
         i2c_busy  <= 1'b0;
      end else begin
         reg_wr   <= 1'b0;
         addr_hit <= 1'b0;
         if (stop_det) begin
            i2c_busy <= 1'b0;
            sda_oe   <= 1'b0;
            hold_cnt <= '0;
            ld_cnt   <= 1'b0;
         end else if (start_det) begin
            i2c_busy <= 1'b1;
            bit_cnt  <= '0;
            sda_oe   <= 1'b0;
            hold_cnt <= '0;
            ld_cnt   <= 1'b0;
         end else begin
            if (scl_fall) begin
               hold_cnt <= HW'(HOLD_CYC);
            end else if (hold_cnt != '0) begin
               hold_cnt <= hold_cnt - HW'(1);
               if (hold_cnt == HW'(1))
                  sda_oe <= drive_low;
            end
            case (state)
               ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        if (state == ST_DEV_ADDR) begin
                           rw_bit   <= rx_byte[RW_BIT];
                           addr_hit <= addr_match;
                        end
                        if (state == ST_REG_ADDR)
                           reg_addr <= rx_byte;
                        if (state == ST_WR_DATA) begin
                           reg_wdata <= rx_byte;
                           reg_wr    <= 1'b1;
                        end
                     end
                  end
               end
               ST_DEV_ACK, ST_REG_ACK: begin
                  if (scl_rise) bit_cnt <= '0;
               end
               ST_WR_ACK: begin
                  if (scl_rise) begin
                     bit_cnt  <= '0;
                     reg_addr <= addr_inc(reg_addr);
                  end
               end
               ST_RD_LOAD: begin
                  // reg_rd is high in the first cycle; data is taken one clk later
                  if (!ld_cnt) begin
                     ld_cnt <= 1'b1;
                  end else begin
                     ld_cnt  <= 1'b0;
                     shreg   <= reg_rdata;
                     bit_cnt <= '0;
                  end
               end
               ST_RD_DATA: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise && !sda)
                     reg_addr <= addr_inc(reg_addr);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
